iir_high_pass_single_pole_mc: RTL and testbench

//  Multi-channel, time-multiplexed single-pole IIR high-pass (DC blocker).

---
 rtl/iir_pkg.sv | 36 +++
 rtl/iir_chan_state.sv | 48 ++++
 rtl/iir_high_pass_single_pole_mc.sv | 100 ++++++++++
 tb/tb_iir_high_pass_single_pole_mc.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared types and saturation helper for the single-pole IIR high-pass.
// Pure combinational helpers, no latency; no flow control.
package iir_pkg;

    localparam int IIR_WIDTH = 16;
    localparam int IIR_GAIN  = 4;
    localparam int IIR_ACC_W = IIR_WIDTH + IIR_GAIN;
    localparam int SAT_MAX_W = 32;

    typedef struct packed {
        logic                        sat;
        logic signed [SAT_MAX_W-1:0] val;
    } sat_t;

    // Clip a signed value to a w-bit signed range; val is meaningful in its low w bits.
    function automatic sat_t sat_signed(input logic signed [SAT_MAX_W:0] x, input int w);
        logic signed [SAT_MAX_W:0] one;
        logic signed [SAT_MAX_W:0] hi;
        logic signed [SAT_MAX_W:0] lo;
        sat_t                      r;
        one   = {{SAT_MAX_W{1'b0}}, 1'b1};
        hi    = (one <<< (w - 1)) - one;
        lo    = -hi - one;
        r.sat = 1'b0;
        r.val = x[SAT_MAX_W-1:0];
        if (x > hi) begin
            r.sat = 1'b1;
            r.val = hi[SAT_MAX_W-1:0];
        end else if (x < lo) begin
            r.sat = 1'b1;
            r.val = lo[SAT_MAX_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/iir_chan_state.sv
// Per-channel leaky-integrator accumulator file: 1 comb read, 1 write, sync clear.
// Read is combinational; write lands on the clock edge.
// No flow control; the caller gates wr_en.
module iir_chan_state
    import iir_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int CH_W     = 2,
    parameter int ACC_W    = IIR_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [CH_W-1:0]  rd_ch,
    output logic [ACC_W-1:0] rd_data,
    output logic             rd_hit,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [ACC_W-1:0] wr_data
);

    logic [ACC_W-1:0] mem [CHANNELS];

    // Tags beyond CHANNELS read as zero with rd_hit low.
    always_comb begin
        rd_data = '0;
        rd_hit  = 1'b0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (rd_ch == CH_W'(i)) begin
                rd_data = mem[i];
                rd_hit  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CHANNELS; i++) mem[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < CHANNELS; i++) mem[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_ch == CH_W'(i)) mem[i] <= wr_data;
            end
        end
    end

endmodule

// File: rtl/iir_high_pass_single_pole_mc.sv
// Multi-channel time-multiplexed single-pole IIR high-pass (DC blocker), saturated output.
// Latency 1 cycle from input acceptance to out_valid; 1 sample/cycle throughput.
// Backpressure: out stage holds while !out_ready; in_ready drops once S1 is also full.
module iir_high_pass_single_pole_mc
    import iir_pkg::*;
#(
    parameter int GAIN     = IIR_GAIN,
    parameter int WIDTH    = IIR_WIDTH,
    parameter int CHANNELS = 4,
    parameter int CH_W     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH_W-1:0]  in_ch,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH_W-1:0]  out_ch,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sat
);

    localparam int ACC_W = WIDTH + GAIN;

    logic                    s1_valid;
    logic [CH_W-1:0]         s1_ch;
    logic signed [WIDTH-1:0] s1_data;

    logic s2_load;
    logic s1_load;
    logic xfer;

    logic [ACC_W-1:0]        rd_data;
    logic                    rd_hit;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [WIDTH-1:0] lp;
    logic signed [WIDTH:0]   hp;
    sat_t                    hp_sat;

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign s1_load  = in_valid && in_ready;
    assign xfer     = s1_valid && s2_load;

    iir_chan_state #(
        .CHANNELS (CHANNELS),
        .CH_W     (CH_W),
        .ACC_W    (ACC_W)
    ) u_state (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .rd_ch    (s1_ch),
        .rd_data  (rd_data),
        .rd_hit   (rd_hit),
        .wr_en    (xfer && rd_hit),
        .wr_ch    (s1_ch),
        .wr_data  (acc_next)
    );

    // Unmapped channel tags bypass the filter: lp forced to zero.
    assign acc      = rd_data;
    assign lp       = rd_hit ? acc[ACC_W-1:GAIN] : '0;
    assign hp       = {s1_data[WIDTH-1], s1_data} - {lp[WIDTH-1], lp};
    assign acc_next = acc + ACC_W'(s1_data) - ACC_W'(lp);
    assign hp_sat   = sat_signed((SAT_MAX_W + 1)'(hp), WIDTH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_ch     <= '0;
            s1_data   <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_ch    <= in_ch;
                s1_data  <= in_data;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
            if (s2_load) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_ch   <= s1_ch;
                    out_data <= hp_sat.val[WIDTH-1:0];
                    out_sat  <= hp_sat.sat;
                end
            end
        end
    end

endmodule

// File: tb/tb_iir_high_pass_single_pole_mc.sv
// Scoreboarded bench for the multi-channel IIR high-pass.
module tb_iir_high_pass_single_pole_mc;

    typedef struct packed {
        logic [1:0]  ch;
        logic [15:0] data;
        logic        sat;
    } smp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_ch = '0;
    logic [15:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_ch;
    logic [15:0] out_data;
    logic        out_sat;

    int checks = 0;
    int errors = 0;

    smp_t sb_q[$];
    smp_t obs_q[$];
    logic signed [19:0] macc [4];
    logic [15:0] dc_exp [200];

    always #5 clk = ~clk;

    iir_high_pass_single_pole_mc dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    // Reference filter: floor(acc/16) low-pass, 20-bit wrapping accumulator, 16-bit clip.
    function automatic smp_t model(input logic [1:0] ch, input logic [15:0] x);
        int   xi, ai, lpi, hpi;
        smp_t r;
        xi    = int'($signed(x));
        ai    = int'(macc[ch]);
        lpi   = ai >>> 4;
        hpi   = xi - lpi;
        r.ch  = ch;
        r.sat = 1'b0;
        if (hpi > 32767) begin
            hpi   = 32767;
            r.sat = 1'b1;
        end else if (hpi < -32768) begin
            hpi   = -32768;
            r.sat = 1'b1;
        end
        r.data   = 16'(hpi);
        macc[ch] = 20'(ai + xi - lpi);
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) macc[i] = '0;
    endtask

    initial begin : monitor
        forever begin : mon_body
            smp_t g;
            smp_t e;
            @(negedge clk);
            if (rst && out_valid && out_ready) begin
                g = '{ch: out_ch, data: out_data, sat: out_sat};
                obs_q.push_back(g);
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_unexpected: got ch=%0d data=%0d sat=%0d, none expected",
                             g.ch, $signed(g.data), g.sat);
                end else begin
                    e = sb_q.pop_front();
                    if (g !== e) begin
                        errors++;
                        $display("FAIL scoreboard: got ch=%0d data=%0d sat=%0d, expected ch=%0d data=%0d sat=%0d",
                                 g.ch, $signed(g.data), g.sat, e.ch, $signed(e.data), e.sat);
                    end
                end
            end
        end
    end

    // Offers one sample; optionally asserts clear on the edge where it moves S1->S2.
    task automatic send(input logic [1:0] ch, input logic [15:0] d, input bit clr_on_xfer,
                        output smp_t e);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        e  = '0;
        in_valid = 1'b1;
        in_ch    = ch;
        in_data  = d;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end else begin
            e = model(ch, d);
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (clr_on_xfer) begin
            clear = 1'b1;
            model_clear();
            @(posedge clk);
            #1;
            clear = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d outputs outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        model_clear();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 16'd0 || out_sat !== 1'b0 || out_ch !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%0b data=%0d sat=%0b ch=%0d, required all 0",
                     out_valid, out_data, out_sat, out_ch);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b, required 1", in_ready);
        end
    endtask

    task automatic test_dc_step();
        smp_t e;
        bit   any_sat;
        obs_q.delete();
        for (int i = 0; i < 200; i++) begin
            send(2'd0, 16'd1000, 1'b0, e);
            dc_exp[i] = e.data;
        end
        drain();
        checks++;
        if (obs_q.size() != 200) begin
            errors++;
            $display("FAIL dc_count: got %0d outputs, required 200", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0].data !== 16'd1000 || obs_q[1].data !== 16'd938 || obs_q[2].data !== 16'd879) begin
                errors++;
                $display("FAIL dc_first3: got %0d %0d %0d, required 1000 938 879",
                         obs_q[0].data, obs_q[1].data, obs_q[2].data);
            end
            checks++;
            if ($signed(obs_q[199].data) > 16 || $signed(obs_q[199].data) < -16) begin
                errors++;
                $display("FAIL dc_settle: got %0d, required within +/-16", $signed(obs_q[199].data));
            end
            any_sat = 1'b0;
            foreach (obs_q[i]) any_sat |= obs_q[i].sat;
            checks++;
            if (any_sat) begin
                errors++;
                $display("FAIL dc_sat: got out_sat=1 during DC step, required 0");
            end
        end
    endtask

    task automatic test_clear();
        smp_t e;
        pulse_clear();
        for (int i = 0; i < 49; i++) send(2'd0, 16'd1000, 1'b0, e);
        send(2'd0, 16'd1000, 1'b1, e);
        obs_q.delete();
        send(2'd0, 16'd1000, 1'b0, e);
        drain();
        checks++;
        if (obs_q.size() < 2 || obs_q[obs_q.size()-1].data !== 16'd1000) begin
            errors++;
            $display("FAIL clear_restart: got %0d outputs, last=%0d, required last 1000",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[obs_q.size()-1].data : 16'd0);
        end
    endtask

    task automatic test_isolation();
        smp_t e;
        int   n0;
        pulse_clear();
        obs_q.delete();
        for (int i = 0; i < 20; i++) begin
            send(2'd0, 16'd1000, 1'b0, e);
            send(2'd1, 16'd0, 1'b0, e);
        end
        drain();
        n0 = 0;
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i].ch == 2'd0) begin
                if (obs_q[i].data !== dc_exp[n0]) begin
                    errors++;
                    $display("FAIL iso_ch0[%0d]: got %0d, required %0d", n0, obs_q[i].data, dc_exp[n0]);
                end
                n0++;
            end else if (obs_q[i].data !== 16'd0) begin
                errors++;
                $display("FAIL iso_ch1: got %0d, required 0", $signed(obs_q[i].data));
            end
        end
        checks++;
        if (n0 != 20) begin
            errors++;
            $display("FAIL iso_count: got %0d ch0 outputs, required 20", n0);
        end
    endtask

    task automatic test_saturation();
        smp_t e;
        obs_q.delete();
        send(2'd2, 16'h7fff, 1'b0, e);
        send(2'd2, 16'h8000, 1'b0, e);
        drain();
        checks++;
        if (obs_q.size() != 2 || obs_q[0].data !== 16'h7fff || obs_q[0].sat !== 1'b0
            || obs_q[1].data !== 16'h8000 || obs_q[1].sat !== 1'b1) begin
            errors++;
            $display("FAIL saturation: got n=%0d out1=%0h/%0b out2=%0h/%0b, required 7fff/0 8000/1",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0].data : 16'h0,
                     (obs_q.size() > 0) ? obs_q[0].sat : 1'b0,
                     (obs_q.size() > 1) ? obs_q[1].data : 16'h0,
                     (obs_q.size() > 1) ? obs_q[1].sat : 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] dv [6];
        logic [15:0] held;
        int idx, acc_cnt, n;
        dv = '{16'd100, 16'd2000, 16'hff00, 16'd7, 16'd3000, 16'd1};
        obs_q.delete();
        idx = 0;
        acc_cnt = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ch     = 2'd3;
        in_data   = dv[0];
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(model(2'd3, dv[idx]));
                idx++;
                acc_cnt++;
            end
            @(posedge clk);
            #1;
            in_data = dv[idx];
        end
        @(negedge clk);
        checks++;
        if (acc_cnt != 2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept: got accepted=%0d in_ready=%0b out_valid=%0b, required 2 0 1",
                     acc_cnt, in_ready, out_valid);
        end
        held = out_data;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (out_data !== held || out_valid !== 1'b1 || out_ch !== 2'd3) begin
            errors++;
            $display("FAIL bp_stable: got data=%0d valid=%0b ch=%0d, required data=%0d valid=1 ch=3",
                     out_data, out_valid, out_ch, held);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        n = 0;
        while (idx < 6 && n < 50) begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(model(2'd3, dv[idx]));
                idx++;
            end
            @(posedge clk);
            #1;
            if (idx < 6) in_data = dv[idx];
            n++;
        end
        in_valid = 1'b0;
        drain();
        checks++;
        if (obs_q.size() != 6) begin
            errors++;
            $display("FAIL bp_count: got %0d outputs, required 6", obs_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        smp_t e;
        in_valid = 1'b1;
        in_ch    = 2'd0;
        in_data  = 16'd300;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (in_ready) sb_q.push_back(model(2'd0, 16'd300));
            @(posedge clk);
            #1;
        end
        #2;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: got out_valid=%0b, required 1", out_valid);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: got out_valid=%0b, required 0", out_valid);
        end
        in_valid = 1'b0;
        sb_q.delete();
        model_clear();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        obs_q.delete();
        send(2'd0, 16'd500, 1'b0, e);
        drain();
        checks++;
        if (obs_q.size() != 1 || obs_q[0].data !== 16'd500) begin
            errors++;
            $display("FAIL midrst_after: got n=%0d data=%0d, required n=1 data=500",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0].data : 16'd0);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        test_reset();
        test_dc_step();
        test_clear();
        test_isolation();
        test_saturation();
        test_back_to_back();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
